dice_operand_collector: RTL and testbench
=========================================

DICE_OPERAND_COLLECTOR -- requirements
Module: dice_operand_collector

Interface
REQ-001 Parameters SHALL be: NUM_BANK, default 4, number of register-file banks.
REQ-002 Parameter WIDTH SHALL default to 32 and sets the operand data width.
REQ-003 Parameter DEPTH SHALL default to 512 and sets the rows per bank.
REQ-004 Parameter NUM_OPS SHALL default to 3 and sets the operand slots per request.
REQ-005 Parameter TAG_WIDTH SHALL default to 8 and sets the width of the request tag carried to the output.
REQ-006 Derived localparams SHALL be ADDR_WIDTH = $clog2(DEPTH), BSEL_WIDTH = $clog2(NUM_BANK), and REG_WIDTH = ADDR_WIDTH + BSEL_WIDTH.
REQ-007 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 in_valid  in  1  request present.
REQ-011 in_ready  out  1  request accepted when both in_valid and in_ready are high.
REQ-012 in_op_en  in  NUM_OPS  per-slot operand-needed mask.
REQ-013 in_op_reg  in  NUM_OPS*REG_WIDTH  per-slot register number; bits [BSEL_WIDTH-1:0] give the bank and the upper bits give the row.
REQ-014 in_tag  in  TAG_WIDTH  opaque tag.
REQ-015 rf_rd_en  out  NUM_BANK  register-file read enables.
REQ-016 rf_rd_addr  out  NUM_BANK*ADDR_WIDTH  register-file row addresses.
REQ-017 rf_rd_data  in  NUM_BANK*WIDTH  register-file read data, valid one cycle after rf_rd_en.
REQ-018 out_valid  out  1  collected operands available.
REQ-019 out_ready  in  1  consumer accepts the output.
REQ-020 out_data  out  NUM_OPS*WIDTH  operand values, slot-ordered.
REQ-021 out_tag  out  TAG_WIDTH  tag of the request being output.

Function
REQ-022 The block SHALL hold one request at a time, using FSM states IDLE, READ and DONE.
REQ-023 in_ready SHALL be high only in IDLE.
REQ-024 On acceptance, the block SHALL register in_op_en, in_op_reg and in_tag.
  - Next state is READ if any in_op_en bit is set.
  - Otherwise next state is DONE.
REQ-025 In READ, each cycle, the block SHALL issue per bank the lowest-indexed slot that is enabled, not yet issued, and mapped to that bank.
  - rf_rd_en[b] is asserted and rf_rd_addr[b] is set to that slot's row.
  - At most one slot per bank is issued per cycle.
REQ-026 Slots issued in cycle C SHALL capture rf_rd_data of their bank at the end of cycle C+1.
  - Issue and capture SHALL overlap, so conflict rounds pipeline back-to-back.
REQ-027 READ SHALL move to DONE on the edge at which the last outstanding slot is captured.
REQ-028 Latency SHALL be as follows, for acceptance edge at the end of cycle T.
  - Conflict-free request: reads in T+1, out_valid from T+3.
  - Each additional same-bank operand adds exactly 1 cycle.
  - No-operand request: out_valid from T+1.
REQ-029 In DONE, out_valid SHALL be 1.
  - out_data and out_tag SHALL be held stable until out_ready is high.
  - The out_valid && out_ready edge returns the FSM to IDLE.
  - A new request is not accepted in the same cycle.
REQ-030 Disabled slots SHALL output all-zero data.
REQ-031 rf_rd_en SHALL be 0, and rf_rd_addr SHALL be 0, whenever the block is not in READ or no slot targets that bank.
REQ-032 in_* inputs SHALL be ignored outside IDLE.
  - Request inputs may change freely after acceptance.
REQ-033 Duplicate register numbers in two slots SHALL be read as separate same-bank reads, lower slot first.

Reset
REQ-034 With rst high at a rising edge, the block SHALL go to IDLE, in the same cycle as or after that edge.
  - All issued/captured masks, out_data and out_tag SHALL clear to 0.
  - out_valid and rf_rd_en SHALL be 0.
  - in_ready SHALL be 1 after the reset edge.
REQ-035 Reset during READ or DONE SHALL abandon the request without further reads.
  - Data returned after reset SHALL be ignored.

Structure
REQ-036 A shared package dice_cgra_pkg SHALL hold the FSM state enum (IDLE/READ/DONE) and the default NUM_BANK/WIDTH/DEPTH constants shared with the register file.
REQ-037 Per-bank lowest-index slot selection SHALL be one sub-module, dice_bank_slot_picker (one instance per bank, combinational priority pick over NUM_OPS).
REQ-038 rf_* ports SHALL connect one-to-one with the register file read ports; no extra buffering is allowed.

Verification
REQ-039 The bench SHALL model the register file with 1-cycle read latency, preloaded with value = 0x1000 + register number.
REQ-040 Scenario: conflict-free.
  - Stimulus: ops en=111, regs 4, 9, 14 (banks 0, 1, 2).
  - Response: reads in T+1, out_valid at T+3, out_data = {0x100E, 0x1009, 0x1004}.
REQ-041 Scenario: full conflict.
  - Stimulus: regs 0, 4, 8 (all bank 0).
  - Response: bank-0 reads rows 0, 1, 2 in T+1..T+3, out_valid at T+5.
REQ-042 Scenario: partial mask and no operands.
  - Stimulus: en=010, reg 7.
  - Response: one bank-3 read, out_data slots 0 and 2 = 0.
  - Stimulus: en=000.
  - Response: out_valid at T+1, no rf_rd_en.
REQ-043 Scenario: backpressure.
  - Stimulus: out_ready low for 5 cycles in DONE.
  - Response: out_valid, out_data and out_tag stable, in_ready 0, then IDLE one cycle after handshake.
REQ-044 Scenario: reset mid-READ.
  - Stimulus: rst asserted in the first read cycle of the full-conflict request.
  - Response: next cycle rf_rd_en = 0, out_valid = 0, in_ready = 1; a following request completes correctly.
REQ-045 Scenario: duplicate registers.
  - Stimulus: regs 5, 5, 5.
  - Response: three serialized bank-1 reads of row 1, all slots = 0x1005.

Source files
------------

// File: rtl/dice_cgra_pkg.sv
// Shared definitions for the DICE CGRA operand path: collector FSM states
// and default register-file geometry used by both collector and register file.
package dice_cgra_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_NUM_BANK = 4;
  localparam int unsigned DEFAULT_WIDTH    = 32;
  localparam int unsigned DEFAULT_DEPTH    = 512;

endpackage

// File: rtl/dice_operand_collector_if.sv
// Request, register-file read and result signals of the operand collector.
// slave: collector side; master: requester / register file / consumer side.
interface dice_operand_collector_if
  import dice_cgra_pkg::*;
#(
  parameter int unsigned NUM_BANK  = DEFAULT_NUM_BANK,
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned NUM_OPS   = 3,
  parameter int unsigned TAG_WIDTH = 8
) ();

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned BSEL_WIDTH = $clog2(NUM_BANK);
  localparam int unsigned REG_WIDTH  = ADDR_WIDTH + BSEL_WIDTH;

  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_OPS-1:0]              in_op_en;
  logic [NUM_OPS*REG_WIDTH-1:0]    in_op_reg;
  logic [TAG_WIDTH-1:0]            in_tag;

  logic [NUM_BANK-1:0]             rf_rd_en;
  logic [NUM_BANK*ADDR_WIDTH-1:0]  rf_rd_addr;
  logic [NUM_BANK*WIDTH-1:0]       rf_rd_data;

  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_OPS*WIDTH-1:0]        out_data;
  logic [TAG_WIDTH-1:0]            out_tag;

  modport slave (
    input  in_valid, in_op_en, in_op_reg, in_tag, rf_rd_data, out_ready,
    output in_ready, rf_rd_en, rf_rd_addr, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_op_en, in_op_reg, in_tag, rf_rd_data, out_ready,
    input  in_ready, rf_rd_en, rf_rd_addr, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/dice_bank_slot_picker.sv
// Combinational priority pick: lowest-indexed candidate slot for one bank.
module dice_bank_slot_picker #(
  parameter int unsigned NUM_OPS   = 3,
  parameter int unsigned IDX_WIDTH = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic [NUM_OPS-1:0]   cand,
  output logic                 valid,
  output logic [NUM_OPS-1:0]   grant,
  output logic [IDX_WIDTH-1:0] idx
);

  // first set bit from slot 0 upward wins
  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (cand[i] && !valid) begin
        valid    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/dice_operand_collector.sv
// Operand collector: accepts one request, reads its operands from a banked
// register file (one read per bank per cycle, 1-cycle latency), presents
// the slot-ordered operands with the request tag.
module dice_operand_collector
  import dice_cgra_pkg::*;
#(
  parameter int unsigned NUM_BANK  = DEFAULT_NUM_BANK,
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned NUM_OPS   = 3,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  dice_operand_collector_if.slave  bus
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned BSEL_WIDTH = $clog2(NUM_BANK);
  localparam int unsigned REG_WIDTH  = ADDR_WIDTH + BSEL_WIDTH;
  localparam int unsigned IDX_WIDTH  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  state_t state_q, state_d;

  logic [NUM_OPS-1:0]                  en_q;
  logic [NUM_OPS-1:0]                  issued_q;
  logic [NUM_OPS-1:0]                  inflight_q;
  logic [NUM_OPS-1:0][REG_WIDTH-1:0]   reg_q;
  logic [NUM_OPS-1:0][WIDTH-1:0]       data_q;
  logic [TAG_WIDTH-1:0]                tag_q;

  logic [NUM_OPS-1:0][BSEL_WIDTH-1:0]  slot_bank;
  logic [NUM_OPS-1:0][ADDR_WIDTH-1:0]  slot_row;
  logic [NUM_BANK-1:0][NUM_OPS-1:0]    cand;
  logic [NUM_BANK-1:0][NUM_OPS-1:0]    grant;
  logic [NUM_BANK-1:0][IDX_WIDTH-1:0]  pick_idx;
  logic [NUM_BANK-1:0]                 bank_hit;
  logic [NUM_BANK-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_BANK-1:0][WIDTH-1:0]      rd_data;
  logic [NUM_OPS-1:0]                  issue_mask;
  logic                                accept;
  logic                                read_done;

  assign rd_data = bus.rf_rd_data;
  assign accept  = (state_q == IDLE) && bus.in_valid;

  // split each held register number into bank select and row
  always_comb begin
    for (int unsigned s = 0; s < NUM_OPS; s++) begin
      slot_bank[s] = reg_q[s][BSEL_WIDTH-1:0];
      slot_row[s]  = reg_q[s][REG_WIDTH-1:BSEL_WIDTH];
    end
  end

  // per-bank candidate slots: enabled, not yet issued, mapped to that bank
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANK; b++) begin
      for (int unsigned s = 0; s < NUM_OPS; s++) begin
        cand[b][s] = (state_q == READ) && en_q[s] && !issued_q[s] &&
                     (slot_bank[s] == BSEL_WIDTH'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    dice_bank_slot_picker #(
      .NUM_OPS   (NUM_OPS),
      .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
      .cand  (cand[b]),
      .valid (bank_hit[b]),
      .grant (grant[b]),
      .idx   (pick_idx[b])
    );
  end

  // drive read ports from the picks; idle banks see zero address
  always_comb begin
    issue_mask = '0;
    for (int unsigned b = 0; b < NUM_BANK; b++) begin
      rd_addr[b] = bank_hit[b] ? slot_row[pick_idx[b]] : '0;
      issue_mask = issue_mask | grant[b];
    end
  end

  // Last capture edge: every enabled slot already issued and nothing new
  // issued this cycle, so only the final in-flight round is being captured.
  assign read_done = ((issued_q | issue_mask) == en_q) && (issue_mask == '0);

  assign bus.rf_rd_en   = bank_hit;
  assign bus.rf_rd_addr = rd_addr;
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_data   = data_q;
  assign bus.out_tag    = tag_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = (|bus.in_op_en) ? READ : DONE;
      READ:    if (read_done) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // request capture, issue bookkeeping and operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= '0;
      issued_q   <= '0;
      inflight_q <= '0;
      reg_q      <= '0;
      data_q     <= '0;
      tag_q      <= '0;
    end else if (accept) begin
      en_q       <= bus.in_op_en;
      reg_q      <= bus.in_op_reg;
      tag_q      <= bus.in_tag;
      issued_q   <= '0;
      inflight_q <= '0;
      data_q     <= '0;
    end else if (state_q == READ) begin
      issued_q   <= issued_q | issue_mask;
      inflight_q <= issue_mask;
      for (int unsigned s = 0; s < NUM_OPS; s++) begin
        if (inflight_q[s]) data_q[s] <= rd_data[slot_bank[s]];
      end
    end
  end

endmodule

// File: tb/tb_dice_operand_collector.sv
// Directed bench for dice_operand_collector with a 1-cycle-latency
// register file model holding 0x1000 + register number.
module tb_dice_operand_collector;
  import dice_cgra_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 9;
  localparam int unsigned RW = 11;
  localparam int unsigned TW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dice_operand_collector_if bus ();

  dice_operand_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // register file model: register number = row*NUM_BANK + bank
  logic [NB*W-1:0] rf_next;
  always_comb begin
    rf_next = '0;
    for (int b = 0; b < NB; b++) begin
      if (bus.rf_rd_en[b])
        rf_next[b*W +: W] = 32'h1000 + 32'(bus.rf_rd_addr[b*AW +: AW]) * NB + 32'(b);
      else
        rf_next[b*W +: W] = 32'hDEAD0000 + 32'(b);
    end
  end
  always @(posedge clk) bus.rf_rd_data <= rf_next;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]    en;
    logic [RW-1:0] r0, r1, r2;
    logic [TW-1:0] tag;
    int            lat;
    int            reads;
    logic [95:0]   data;
  } vec_t;

  vec_t vecs [7];

  task automatic accept_req(input logic [2:0] en, input logic [RW-1:0] r0, r1, r2,
                            input logic [TW-1:0] tag);
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_op_en  = en;
    bus.in_op_reg = {r2, r1, r0};
    bus.in_tag    = tag;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_op_en  = 3'($urandom);
    bus.in_op_reg = 33'($urandom);
    bus.in_tag    = 8'($urandom);
  endtask

  task automatic wait_valid(output int lat, output int reads, output bit addr_bad);
    lat = 0; reads = 0; addr_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      reads += $countones(bus.rf_rd_en);
      for (int b = 0; b < NB; b++)
        if (!bus.rf_rd_en[b] && bus.rf_rd_addr[b*AW +: AW] != '0) addr_bad = 1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_hs", bus.in_ready, 1);
    check("out_valid_after_hs", bus.out_valid, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat, reads;
    bit bad;
    accept_req(v.en, v.r0, v.r1, v.r2, v.tag);
    wait_valid(lat, reads, bad);
    check("latency", 128'(lat), 128'(v.lat));
    check("read_count", 128'(reads), 128'(v.reads));
    check("idle_addr_zero", 128'(bad), 0);
    check("out_data", bus.out_data, v.data);
    check("out_tag", bus.out_tag, v.tag);
    check("in_ready_busy", bus.in_ready, 0);
    handshake();
  endtask

  // three same-bank reads; row sequence checked cycle by cycle
  task automatic run_serial(input string name, input logic [RW-1:0] r0, r1, r2,
                            input int bank, input logic [AW-1:0] row0, row1, row2,
                            input logic [95:0] data);
    logic [AW-1:0] rows [3];
    rows[0] = row0; rows[1] = row1; rows[2] = row2;
    accept_req(3'b111, r0, r1, r2, 8'h33);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({name, "_en"}, bus.rf_rd_en, 128'(1) << bank);
      check({name, "_row"}, bus.rf_rd_addr[bank*AW +: AW], rows[k]);
      check({name, "_valid_low"}, bus.out_valid, 0);
    end
    @(negedge clk);
    check({name, "_en_drain"}, bus.rf_rd_en, 0);
    check({name, "_valid_drain"}, bus.out_valid, 0);
    @(negedge clk);
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_data"}, bus.out_data, data);
    handshake();
  endtask

  initial begin
    int lat, reads;
    bit bad;
    logic [95:0] held_data;
    logic [TW-1:0] held_tag;

    vecs[0] = '{3'b111, 11'd4, 11'd9, 11'd14, 8'hA1, 3, 3, {32'h100E, 32'h1009, 32'h1004}};
    vecs[1] = '{3'b111, 11'd0, 11'd4, 11'd8,  8'hB2, 5, 3, {32'h1008, 32'h1004, 32'h1000}};
    vecs[2] = '{3'b010, 11'd3, 11'd7, 11'd11, 8'hC3, 3, 1, {32'h0,    32'h1007, 32'h0}};
    vecs[3] = '{3'b000, 11'd1, 11'd2, 11'd3,  8'hD4, 1, 0, 96'h0};
    vecs[4] = '{3'b111, 11'd5, 11'd5, 11'd5,  8'hE5, 5, 3, {32'h1005, 32'h1005, 32'h1005}};
    vecs[5] = '{3'b101, 11'd1, 11'd2, 11'd5,  8'hF6, 4, 2, {32'h1005, 32'h0,    32'h1001}};
    vecs[6] = '{3'b111, 11'd2, 11'd6, 11'd3,  8'h17, 4, 3, {32'h1003, 32'h1006, 32'h1002}};

    bus.in_valid  = 1'b0;
    bus.in_op_en  = '0;
    bus.in_op_reg = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_rd_en", bus.rf_rd_en, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_tag", bus.out_tag, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    run_serial("conflict", 11'd0, 11'd4, 11'd8, 0, 9'd0, 9'd1, 9'd2,
               {32'h1008, 32'h1004, 32'h1000});
    run_serial("dup", 11'd5, 11'd5, 11'd5, 1, 9'd1, 9'd1, 9'd1,
               {32'h1005, 32'h1005, 32'h1005});

    // backpressure: output held while consumer stalls
    accept_req(3'b111, 11'd4, 11'd9, 11'd14, 8'h5A);
    wait_valid(lat, reads, bad);
    check("bp_latency", 128'(lat), 3);
    held_data = bus.out_data;
    held_tag  = bus.out_tag;
    check("bp_data", held_data, {32'h100E, 32'h1009, 32'h1004});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", bus.out_valid, 1);
      check("bp_data_stable", bus.out_data, held_data);
      check("bp_tag_stable", bus.out_tag, 8'h5A);
      check("bp_in_ready", bus.in_ready, 0);
    end
    handshake();

    // reset during the first read cycle of a full-conflict request
    accept_req(3'b111, 11'd0, 11'd4, 11'd8, 8'h99);
    @(negedge clk);
    check("mid_rst_first_read", bus.rf_rd_en, 4'b0001);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rd_en", bus.rf_rd_en, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_tag", bus.out_tag, 0);
    @(negedge clk);
    check("mid_rst_quiet", bus.rf_rd_en, 0);
    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
